mux_arbiter: RTL
================

Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 32-bit 2:1 datapath mux (inputs A/B, select S, output X) between two producers.
- Each side uses a valid/ready handshake. The winner's word passes through the mux into a one-entry output register.
- Drives S so downstream logic knows the source of the word on X.
- Sits between two datapath sources (e.g. ALU result, memory read) and a single write-back consumer.

Parameters:
- WIDTH, 32, data width of A, B, X.
- BURST_LEN, 4, maximum consecutive transfers granted to one requester while the other is waiting; legal range 1..15.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- A  input  WIDTH  requester A data.
- A_VALID  input  1  requester A has data.
- A_READY  output  1  A transfer accepted this cycle when A_VALID && A_READY.
- B  input  WIDTH  requester B data.
- B_VALID  input  1  requester B has data.
- B_READY  output  1  B transfer accepted this cycle when B_VALID && B_READY.
- X  output  WIDTH  registered mux output.
- X_VALID  output  1  X holds an unconsumed word.
- X_READY  input  1  consumer accepts X when X_VALID && X_READY.
- S  output  1  registered source of X: 0 = A, 1 = B.

Behaviour:
- Reset (async, RST=1): X=0, X_VALID=0, S=0, state=IDLE, LAST=B (so A wins the first tie), burst_cnt=0. Any word held in X is discarded. A_READY and B_READY are 0 while RST is high.
- slot = !X_VALID || X_READY. When slot=0, A_READY=B_READY=0 and all state holds.
- States: IDLE, OWN_A, OWN_B, with owner = A or B respectively.
- Pick (combinational, only when slot=1):
  - IDLE: only one requester valid -> that one. Both valid -> the requester != LAST.
  - OWN_x: owner valid and (other not valid or burst_cnt < BURST_LEN) -> owner. Otherwise, other valid -> other. Neither -> none.
- READY: the picked side's READY=1; the other side's READY=0. No pick -> both 0. READY never depends on the READY of the same side.
- Transfer on pick: next cycle X = picked data, S = picked index, X_VALID=1, LAST = picked, state = OWN_picked.
  - burst_cnt = burst_cnt+1 if picked == previous owner; otherwise 1.
  - burst_cnt saturates at BURST_LEN.
- Slot with no pick: X_VALID<=0 if X_READY consumed the word. State -> IDLE, burst_cnt -> 0, LAST retained.
- Latency: 1 cycle from input handshake to X_VALID. Throughput: 1 word/cycle when X_READY is held high.
- Backpressure: with X_VALID=1 and X_READY=0, X and S are stable and no input is accepted.
- Simultaneous consume and accept in the same cycle is allowed: X is replaced with no bubble.
- BURST_LEN=1 gives strict alternation under contention.
- A requester dropping VALID mid-burst loses ownership at the next slot if the other side is valid.

Optional Feature:
- Macro: MUX_ARBITER_STATS_EN.
- With the macro defined:
  - Adds outputS CNT_A[15:0] and CNT_B[15:0], counting accepted transfers per requester. Both wrap at 16'hFFFF -> 0 and reset to 0.
  - Adds output STALL[15:0], counting cycles with X_VALID=1 && X_READY=0. Saturates at 16'hFFFF.
- Without the macro: these ports and registers are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package mux_arbiter_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN_A=2'd1, ST_OWN_B=2'd2;
  - source constants SRC_A=1'b0, SRC_B=1'b1;
  - default WIDTH=32.
- One natural sub-module, rr_pick: pure combinational pick logic (inputs state, LAST, burst_cnt, A_VALID, B_VALID, slot; outputs pick_valid, pick_src). This allows the pick logic to be checked exhaustively in isolation.
- The existing mux module is instantiated for the data path, with S driven by pick_src.

Test Plan:
- Reset mid-transfer: X_VALID=1, X=32'h0000FFFF, then RST pulse -> X=0, X_VALID=0, S=0 immediately, without waiting for CLK; A_READY=B_READY=0 while RST is high.
- Single requester: A=32'h12874321 with A_VALID=1 for 1 cycle, X_READY=1 -> next cycle X=32'h12874321, S=0, X_VALID=1; following cycle X_VALID=0.
- Tie after reset: A=32'h0000FFFF and B=32'hFFFF0000 both valid, X_READY=1, BURST_LEN=4 -> S sequence 0,0,0,0,1,1,1,1,0 with the matching data each cycle.
- Backpressure: X_READY=0 for 5 cycles with both valid -> X, S stable, A_READY=B_READY=0; on X_READY=1, one transfer completes per cycle with no data loss or duplication.
- BURST_LEN=1: A and B continuously valid -> S alternates 0,1,0,1; B dropping VALID gives A consecutive grants with burst_cnt saturating.
- MUX_ARBITER_STATS_EN defined: 10 A and 6 B transfers plus 3 stalled cycles -> CNT_A=10, CNT_B=6, STALL=3.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared encodings and helpers for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Burst length of the new owner: extend and saturate on a repeat grant, restart at 1 otherwise.
    function automatic logic [3:0] next_burst(input logic same_owner,
                                              input logic [3:0] cnt,
                                              input logic [3:0] max_cnt);
        logic [3:0] result;
        if (same_owner) begin
            if (cnt < max_cnt) begin
                result = cnt + 4'd1;
            end else begin
                result = max_cnt;
            end
        end else begin
            result = 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux.sv
// Plain 2:1 datapath mux: X follows A when S=0, B when S=1.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] X
);

    assign X = S ? B : A;

endmodule

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin pick for the mux arbiter; a pick is only made when the output slot is free.
module rr_pick
    import mux_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  state_e     i_state,
    input  logic       i_last,
    input  logic [3:0] i_burst_cnt,
    input  logic       i_a_valid,
    input  logic       i_b_valid,
    input  logic       i_slot,
    output logic       o_pick_valid,
    output logic       o_pick_src
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    logic w_under_limit;
    assign w_under_limit = (i_burst_cnt < BURST_MAX);

    // Owner keeps the grant until its burst is spent and the other side is waiting.
    always_comb begin
        o_pick_valid = 1'b0;
        o_pick_src   = SRC_A;
        if (i_slot) begin
            case (i_state)
                ST_IDLE: begin
                    if (i_a_valid && i_b_valid) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = ~i_last;
                    end else if (i_a_valid) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_A;
                    end else if (i_b_valid) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_B;
                    end else begin
                        o_pick_valid = 1'b0;
                    end
                end
                ST_OWN_A: begin
                    if (i_a_valid && (!i_b_valid || w_under_limit)) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_A;
                    end else if (i_b_valid) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_B;
                    end else begin
                        o_pick_valid = 1'b0;
                    end
                end
                ST_OWN_B: begin
                    if (i_b_valid && (!i_a_valid || w_under_limit)) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_B;
                    end else if (i_a_valid) begin
                        o_pick_valid = 1'b1;
                        o_pick_src   = SRC_A;
                    end else begin
                        o_pick_valid = 1'b0;
                    end
                end
                default: begin
                    o_pick_valid = 1'b0;
                    o_pick_src   = SRC_A;
                end
            endcase
        end else begin
            o_pick_valid = 1'b0;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between two valid/ready producers into a one-entry output register.
// Optional transfer/stall counters are enabled with MUX_ARBITER_STATS_EN.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_LEN = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic             A_VALID,
    output logic             A_READY,
    input  logic [WIDTH-1:0] B,
    input  logic             B_VALID,
    output logic             B_READY,
    output logic [WIDTH-1:0] X,
    output logic             X_VALID,
    input  logic             X_READY,
    output logic             S
`ifdef MUX_ARBITER_STATS_EN
    ,
    output logic [15:0]      CNT_A,
    output logic [15:0]      CNT_B,
    output logic [15:0]      STALL
`endif
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    logic [WIDTH-1:0] r_x;
    logic             r_x_valid;
    logic             r_s;
    state_e           r_state;
    logic             r_last;
    logic [3:0]       r_burst_cnt;

    logic             w_slot;
    logic             w_pick_valid;
    logic             w_pick_src;
    logic             w_same_owner;
    logic [WIDTH-1:0] w_mux_x;

    // Reset gates the slot so no handshake is offered while RST is asserted.
    assign w_slot = !RST && (!r_x_valid || X_READY);

    rr_pick #(
        .BURST_LEN (BURST_LEN)
    ) u_rr_pick (
        .i_state      (r_state),
        .i_last       (r_last),
        .i_burst_cnt  (r_burst_cnt),
        .i_a_valid    (A_VALID),
        .i_b_valid    (B_VALID),
        .i_slot       (w_slot),
        .o_pick_valid (w_pick_valid),
        .o_pick_src   (w_pick_src)
    );

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .A (A),
        .B (B),
        .S (w_pick_src),
        .X (w_mux_x)
    );

    assign w_same_owner = ((r_state == ST_OWN_A) && (w_pick_src == SRC_A)) ||
                          ((r_state == ST_OWN_B) && (w_pick_src == SRC_B));

    assign A_READY = w_pick_valid && (w_pick_src == SRC_A);
    assign B_READY = w_pick_valid && (w_pick_src == SRC_B);
    assign X       = r_x;
    assign X_VALID = r_x_valid;
    assign S       = r_s;

    // Output register, ownership state and burst counter advance only when the slot is free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_x         <= '0;
            r_x_valid   <= 1'b0;
            r_s         <= SRC_A;
            r_state     <= ST_IDLE;
            r_last      <= SRC_B;
            r_burst_cnt <= 4'd0;
        end else if (w_slot) begin
            if (w_pick_valid) begin
                r_x         <= w_mux_x;
                r_s         <= w_pick_src;
                r_x_valid   <= 1'b1;
                r_last      <= w_pick_src;
                r_state     <= (w_pick_src == SRC_B) ? ST_OWN_B : ST_OWN_A;
                r_burst_cnt <= next_burst(w_same_owner, r_burst_cnt, BURST_MAX);
            end else begin
                r_x_valid   <= 1'b0;
                r_state     <= ST_IDLE;
                r_burst_cnt <= 4'd0;
            end
        end
    end

`ifdef MUX_ARBITER_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;
    logic [15:0] r_stall;

    // Transfer counters wrap; the stall counter sticks at its maximum.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt_a <= 16'd0;
            r_cnt_b <= 16'd0;
            r_stall <= 16'd0;
        end else begin
            if (A_VALID && A_READY) begin
                r_cnt_a <= r_cnt_a + 16'd1;
            end
            if (B_VALID && B_READY) begin
                r_cnt_b <= r_cnt_b + 16'd1;
            end
            if (r_x_valid && !X_READY && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign CNT_A = r_cnt_a;
    assign CNT_B = r_cnt_b;
    assign STALL = r_stall;
`endif

endmodule
